pipelined_shifter: RTL and testbench
====================================

Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the datapath's combinational shifter.
- Shifts or rotates a WIDTH-bit operand by a runtime amount. Supports four modes: logical left, logical right, arithmetic right and rotate right.
- Also produces carry-out (last bit shifted out) and zero flags.
- Sits between the ALU operand mux and the writeback stage, with valid/ready handshakes on both sides so the datapath can stall it.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64.
- SA_W, $clog2(WIDTH), shift-amount width (derived; not overridden).
- REG_EVERY, 2, number of log2 shift stages between pipeline registers; 1..SA_W.
- LATENCY, ceil(SA_W/REG_EVERY), cycles from input accept to output valid (derived; 3 at defaults).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, input operand valid.
- in_ready, output, 1, block can accept input this cycle.
- in_data, input, WIDTH, operand.
- in_sa, input, SA_W, shift amount.
- in_mode, input, 2, shift mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts result.
- out_data, output, WIDTH, shifted result.
- out_carry, output, 1, last bit shifted out.
- out_zero, output, 1, out_data == 0.

Behaviour:
- Reset (sync, on clk edge with reset=1): all stage valid bits cleared, so out_valid=0. out_data, out_carry and out_zero are 0. In-flight operations are discarded.
- Reset mid-operation: anything accepted before the reset edge is dropped. in_ready is 1 in the first cycle after reset deasserts.
- Shift structure: log2 stages in order 2^(SA_W-1) down to 1. Each stage applies its shift only if its in_sa bit is set. A pipeline register follows every REG_EVERY stages and after the last stage.
- Per-stage register contents: data, remaining in_sa bits, mode, guard bit.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - Input is accepted when in_valid && in_ready.
  - When advance=1, every stage register loads from its predecessor, including the valid bit. Stage 0 loads in_valid && in_ready.
  - When advance=0, all stages hold (global stall); no bubble compression.
- Latency: a result accepted at edge N appears with out_valid=1 after edge N+LATENCY-1, i.e. in cycle N+LATENCY.
- Throughput: one operation per cycle when out_ready stays high.
- Output stability: out_data, out_carry and out_zero are held stable while out_valid && !out_ready.
- Mode arithmetic:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with in_data[WIDTH-1], captured at input.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Carry:
  - sa=0 in any mode: carry=0.
  - SLL: carry = in_data[WIDTH-sa].
  - SRL/SRA: carry = in_data[sa-1].
  - ROR: carry = out_data[WIDTH-1].
  - Implementation: a one-bit guard carried through the stages; each active stage overwrites the guard with the last bit that stage shifts out.
- Zero: computed combinationally from the final register, equal to (out_data==0).
- Maximum shift is WIDTH-1. No out-of-range amounts exist.
- Mode is sampled at input and travels with its data. Mixed modes back-to-back must not interfere.

Decomposition:
- Shared package shifter_pkg holds:
  - shift_mode_t enum (SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROR=2'b11);
  - a function computing LATENCY from WIDTH and REG_EVERY.
- One natural sub-module: shift_stage. It is combinational, parameterised by WIDTH and stage distance D, with inputs data, guard, enable and mode, and outputs data and guard.
- pipelined_shifter instantiates SA_W shift_stage instances via generate and inserts the registers and valid chain.

Test Plan:
- Reset/idle: hold reset 3 cycles with in_valid=1 -> out_valid=0 throughout. in_ready=1 on the first cycle after release.
- Modes (WIDTH=32): in_data=0x8000_00F1, sa=4, with out_ready=1.
  - SLL -> 0x0000_0F10, carry=0.
  - SRL -> 0x0800_000F, carry=0.
  - SRA -> 0xF800_000F, carry=0.
  - ROR -> 0x1800_000F, carry=0.
  - Each result arrives exactly 3 cycles after accept.
- Boundaries:
  - SLL 0x0000_0001 by 31 -> 0x8000_0000, carry=0, zero=0.
  - SRL 0x8000_0000 by 31 -> 0x0000_0001.
  - SLL 0x0000_0003 by 31 -> 0x8000_0000, carry=1.
  - sa=0 in any mode -> data unchanged, carry=0.
  - SRL 0x0000_0001 by 1 -> 0x0, carry=1, zero=1.
- Backpressure: stream 6 operations back-to-back while out_ready is low for 4 cycles mid-stream -> in_ready low during the stall, outputs held stable, all 6 results in order, none lost or duplicated.
- Reset mid-flight: accept 2 operations, assert reset one cycle later -> neither result ever appears; the next post-reset operation completes normally.
- Parameter sweep: WIDTH=8/REG_EVERY=1 (LATENCY=3) and WIDTH=64/REG_EVERY=3 (LATENCY=2) -> random operands match the reference model, latency equals LATENCY.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: shift_mode_t (operation encoding on in_mode) and calc_latency(),
// which gives the number of pipeline registers for a width / grouping pair.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_mode_t;

    // One register per group of reg_every log2 stages, plus one after a
    // trailing partial group: ceil($clog2(width) / reg_every).
    function automatic int calc_latency(input int width, input int reg_every);
        int sa_w;
        sa_w = $clog2(width);
        return (sa_w + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One log2 stage of the shifter: optionally shifts/rotates by a fixed distance D.
// Latency: 0 (purely combinational).
// Backpressure: none; the enclosing pipeline owns all flow control.
//
// Ports: data_i/guard_i  operand and carry guard from the previous stage
//        en_i            this stage's shift-amount bit
//        mode_i          shift mode travelling with the operand
//        data_o/guard_o  result and updated guard
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int D     = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             guard_i,
    input  logic             en_i,
    input  shift_mode_t      mode_i,
    output logic [WIDTH-1:0] data_o,
    output logic             guard_o
);

    always_comb begin
        data_o  = data_i;
        guard_o = guard_i;
        if (en_i) begin
            // The guard keeps the last bit this stage pushes out; smaller
            // stages run later, so the final guard is the overall carry.
            // For ROR this bit lands at the MSB, matching out_data[WIDTH-1].
            guard_o = (mode_i == SHIFT_SLL) ? data_i[WIDTH-D] : data_i[D-1];
            case (mode_i)
                SHIFT_SLL: data_o = {data_i[WIDTH-1-D:0], {D{1'b0}}};
                SHIFT_SRL: data_o = {{D{1'b0}}, data_i[WIDTH-1:D]};
                // The MSB is never altered by earlier right shifts in SRA
                // mode, so it still holds the sign captured at input.
                SHIFT_SRA: data_o = {{D{data_i[WIDTH-1]}}, data_i[WIDTH-1:D]};
                SHIFT_ROR: data_o = {data_i[D-1:0], data_i[WIDTH-1:D]};
                default:   data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR by a runtime amount, with carry and zero flags.
// Latency: LATENCY = ceil(SA_W/REG_EVERY) cycles from accept to out_valid; one op per cycle.
// Backpressure: global stall; in_ready = !out_valid || out_ready, whole pipe holds when low.
//
// Ports: clk, reset (sync, active high)
//        in_valid/in_ready, in_data, in_sa, in_mode   operand side
//        out_valid/out_ready, out_data, out_carry, out_zero   writeback side
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int REG_EVERY = 2,
    localparam int SA_W      = $clog2(WIDTH),
    localparam int LATENCY   = calc_latency(WIDTH, REG_EVERY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SA_W-1:0]  in_sa,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    logic advance;

    // c_* is the view presented to stage s (index SA_W is the final register).
    logic [WIDTH-1:0] c_data  [SA_W+1];
    logic             c_guard [SA_W+1];
    logic [SA_W-1:0]  c_sa    [SA_W];
    shift_mode_t      c_mode  [SA_W];
    logic [WIDTH-1:0] s_data  [SA_W];
    logic             s_guard [SA_W];

    logic [LATENCY-1:0] vld_q, vld_d;

    assign out_valid = vld_q[LATENCY-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    assign c_data[0]  = in_data;
    assign c_guard[0] = 1'b0;
    assign c_sa[0]    = in_sa;
    assign c_mode[0]  = shift_mode_t'(in_mode);

    // Valid chain: bit r belongs to pipeline register r.
    always_comb begin
        vld_d = vld_q;
        if (advance) begin
            vld_d = (vld_q << 1) | LATENCY'(in_valid && in_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    for (genvar s = 0; s < SA_W; s++) begin : g_stage
        // Largest distance first: stage s handles in_sa bit SA_W-1-s.
        localparam int  D      = 1 << (SA_W - 1 - s);
        localparam bit  IS_REG = ((s + 1) % REG_EVERY == 0) || (s == SA_W - 1);

        shift_stage #(
            .WIDTH (WIDTH),
            .D     (D)
        ) u_stage (
            .data_i  (c_data[s]),
            .guard_i (c_guard[s]),
            .en_i    (c_sa[s][SA_W-1-s]),
            .mode_i  (c_mode[s]),
            .data_o  (s_data[s]),
            .guard_o (s_guard[s])
        );

        if (IS_REG) begin : g_reg
            logic [WIDTH-1:0] data_q, data_d;
            logic             guard_q, guard_d;

            always_comb begin
                data_d  = data_q;
                guard_d = guard_q;
                if (advance) begin
                    data_d  = s_data[s];
                    guard_d = s_guard[s];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q  <= '0;
                    guard_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    guard_q <= guard_d;
                end
            end

            assign c_data[s+1]  = data_q;
            assign c_guard[s+1] = guard_q;

            // Shift amount and mode are only needed while stages remain.
            if (s < SA_W - 1) begin : g_ctl
                logic [SA_W-1:0] sa_q, sa_d;
                shift_mode_t     mode_q, mode_d;

                always_comb begin
                    sa_d   = sa_q;
                    mode_d = mode_q;
                    if (advance) begin
                        sa_d   = c_sa[s];
                        mode_d = c_mode[s];
                    end
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        sa_q   <= '0;
                        mode_q <= SHIFT_SLL;
                    end else begin
                        sa_q   <= sa_d;
                        mode_q <= mode_d;
                    end
                end

                assign c_sa[s+1]   = sa_q;
                assign c_mode[s+1] = mode_q;
            end
        end else begin : g_thru
            assign c_data[s+1]  = s_data[s];
            assign c_guard[s+1] = s_guard[s];
            assign c_sa[s+1]    = c_sa[s];
            assign c_mode[s+1]  = c_mode[s];
        end
    end

    assign out_data  = c_data[SA_W];
    assign out_carry = c_guard[SA_W];
    // Qualified by valid so an idle or freshly reset output reads zero=0.
    assign out_zero  = out_valid && (c_data[SA_W] == '0);

endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;

    localparam int NI = 3;  // instance 0: 32/2, 1: 8/1, 2: 64/3

    logic clk = 1'b0;
    logic reset;
    logic iv [NI], ir [NI], ov [NI], ordy [NI], oc [NI], oz [NI];
    logic [63:0] idat [NI];
    logic [5:0]  isa [NI];
    logic [1:0]  imode [NI];
    logic [31:0] od32;
    logic [7:0]  od8;
    logic [63:0] od64;

    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(32), .REG_EVERY(2)) dut (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(idat[0][31:0]), .in_sa(isa[0][4:0]), .in_mode(imode[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od32),
        .out_carry(oc[0]), .out_zero(oz[0]));

    pipelined_shifter #(.WIDTH(8), .REG_EVERY(1)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(idat[1][7:0]), .in_sa(isa[1][2:0]), .in_mode(imode[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od8),
        .out_carry(oc[1]), .out_zero(oz[1]));

    pipelined_shifter #(.WIDTH(64), .REG_EVERY(3)) dut64 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(idat[2]), .in_sa(isa[2]), .in_mode(imode[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od64),
        .out_carry(oc[2]), .out_zero(oz[2]));

    typedef struct {
        logic [63:0] d;
        logic        c;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    int          n_cmp = 0, n_err = 0, cyc = 0, n_out = 0;
    bit          lat_chk = 1'b0;
    bit          held_vld = 1'b0;
    logic [63:0] held_d;
    logic        held_c;
    bit          acc_o;

    function automatic int wid_of(input int k);
        return (k == 0) ? 32 : (k == 1) ? 8 : 64;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 2) ? 2 : 3;
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] get_odat(input int k);
        return (k == 0) ? {32'h0, od32} : (k == 1) ? {56'h0, od8} : od64;
    endfunction

    // Reference: whole-word arithmetic on the original operand.
    function automatic void ref_model(input int w, input logic [63:0] din, input int sa,
                                      input logic [1:0] m, output logic [63:0] r,
                                      output logic c);
        logic [63:0] mask, d;
        mask = mask_of(w);
        d    = din & mask;
        c    = 1'b0;
        case (m)
            2'b00: begin
                r = (d << sa) & mask;
                if (sa != 0) c = d[w-sa];
            end
            2'b01: begin
                r = d >> sa;
                if (sa != 0) c = d[sa-1];
            end
            2'b10: begin
                r = d >> sa;
                if (d[w-1]) r = r | (mask & ~(mask >> sa));
                if (sa != 0) c = d[sa-1];
            end
            default: begin
                r = ((d >> sa) | (d << (w - sa))) & mask;
                if (sa != 0) c = r[w-1];
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // One cycle for instance k: inputs were driven at the preceding negedge.
    task automatic step(input int k, output bit acc);
        exp_t        e;
        logic [63:0] od;
        #1;
        od = get_odat(k);
        if (held_vld) begin
            check("hold_valid", ov[k], 1'b1);
            check("hold_data", od, held_d);
            check("hold_carry", oc[k], held_c);
        end
        check("in_ready", ir[k], !ov[k] || ordy[k]);
        if (ov[k] && ordy[k]) begin
            n_out++;
            check("out_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("data", od, e.d);
                check("carry", oc[k], e.c);
                check("zero", oz[k], e.d == 64'h0);
                if (lat_chk) check("latency", cyc - e.cyc, lat_of(k));
            end
        end
        held_vld = ov[k] && !ordy[k];
        held_d   = od;
        held_c   = oc[k];
        acc = iv[k] && ir[k];
        if (acc) begin
            ref_model(wid_of(k), idat[k], int'(isa[k]), imode[k], e.d, e.c);
            e.cyc = cyc;
            sb.push_back(e);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input int k, input logic [63:0] d, input int sa, input logic [1:0] m);
        iv[k]    = 1'b1;
        idat[k]  = d & mask_of(wid_of(k));
        isa[k]   = 6'(sa);
        imode[k] = m;
    endtask

    task automatic send(input int k, input logic [63:0] d, input int sa, input logic [1:0] m);
        bit acc;
        acc = 1'b0;
        drive(k, d, sa, m);
        for (int i = 0; i < 20 && !acc; i++) step(k, acc);
        check("send_accept", acc, 1'b1);
        iv[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        bit acc;
        iv[k]   = 1'b0;
        ordy[k] = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) step(k, acc);
        check("drain_left", sb.size(), 0);
    endtask

    task automatic rand_phase(input int k, input int ncyc, input bit stall);
        bit acc;
        acc     = 1'b0;
        lat_chk = !stall;
        iv[k]   = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            ordy[k] = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!iv[k] || acc) begin
                if ($urandom_range(0, 9) < 7)
                    drive(k, {$urandom, $urandom}, $urandom_range(0, wid_of(k) - 1),
                          2'($urandom_range(0, 3)));
                else
                    iv[k] = 1'b0;
            end
            step(k, acc);
        end
        drain(k);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    initial begin
        int base, sent;
        bit acc;
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            iv[k] = 1'b1; ordy[k] = 1'b1; idat[k] = {$urandom, $urandom};
            isa[k] = 6'd1; imode[k] = 2'b00;
        end
        repeat (3) begin
            @(posedge clk); #1;
            for (int k = 0; k < NI; k++) check("reset_out_valid", ov[k], 1'b0);
        end
        for (int k = 0; k < NI; k++) begin
            check("reset_data", get_odat(k), 64'h0);
            check("reset_carry", oc[k], 1'b0);
            check("reset_zero", oz[k], 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < NI; k++) iv[k] = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) check("ready_after_reset", ir[k], 1'b1);
        @(negedge clk);

        // All four modes back-to-back on the same operand.
        lat_chk = 1'b1;
        for (int m = 0; m < 4; m++) send(0, 64'h8000_00F1, 4, 2'(m));
        drain(0);

        // Boundary amounts.
        send(0, 64'h0000_0001, 31, 2'b00);
        send(0, 64'h8000_0000, 31, 2'b01);
        send(0, 64'h0000_0003, 31, 2'b00);
        send(0, 64'h8000_0000, 31, 2'b10);
        send(0, 64'h8000_0001, 31, 2'b11);
        for (int m = 0; m < 4; m++) send(0, 64'hA5C3_0F96, 0, 2'(m));
        send(0, 64'h0000_0001, 1, 2'b01);
        drain(0);

        // Backpressure: 6 ops back-to-back, out_ready low for 4 cycles mid-stream.
        lat_chk = 1'b0;
        base = n_out;
        sent = 0;
        acc  = 1'b0;
        iv[0] = 1'b0;
        for (int c = 0; c < 40 && (sent < 6 || sb.size() > 0); c++) begin
            ordy[0] = !(c >= 3 && c < 7);
            if (!iv[0] || acc) begin
                if (sent < 6) drive(0, {32'h0, $urandom}, $urandom_range(0, 31), 2'($urandom_range(0, 3)));
                else iv[0] = 1'b0;
            end
            step(0, acc);
            if (acc) sent++;
        end
        check("bp_result_count", n_out - base, 6);
        drain(0);

        // Reset one cycle after two accepts: both results must vanish.
        send(0, 64'h1234_5678, 3, 2'b00);
        send(0, 64'h8765_4321, 5, 2'b11);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        held_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0, acc);
            check("flushed_out_valid", ov[0], 1'b0);
        end
        lat_chk = 1'b1;
        send(0, 64'hF0F0_0001, 7, 2'b10);
        drain(0);

        // Randomised streams on every parameter set.
        for (int k = 0; k < NI; k++) begin
            rand_phase(k, 60, 1'b0);
            rand_phase(k, 80, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
